// File: rtl/div_unit_if.sv
// Bundle of signals between the E stage and the iterative divider.
// The E stage holds start high until ready, and stall_div tells the hazard unit to freeze E meanwhile.
interface div_unit_if #(
    parameter int WIDTH = 32
) ();
    logic [WIDTH-1:0]   opdata1;
    logic [WIDTH-1:0]   opdata2;
    logic               signed_div;
    logic               start;
    logic               annul;
    logic [2*WIDTH-1:0] result;
    logic               ready;
    logic               stall_div;
    logic [1:0]         dbg_state;

    modport master (
        output opdata1, opdata2, signed_div, start, annul,
        input  result, ready, stall_div, dbg_state
    );

    modport slave (
        input  opdata1, opdata2, signed_div, start, annul,
        output result, ready, stall_div, dbg_state
    );
endinterface

// File: rtl/div_unit.sv
// Iterative 32-step restoring divider for DIV/DIVU with a zero-divisor shortcut.
// result is {remainder, quotient}, and it is valid only in the single cycle when ready is high.
module div_unit #(
    parameter int WIDTH = 32
) (
    input logic       clk,
    input logic       rst,
    div_unit_if.slave bus
);
    typedef enum logic [1:0] {
        FREE = 2'd0,
        ZERO = 2'd1,
        ON   = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [5:0]         cnt_q, cnt_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic               neg_quo_q, neg_quo_d;
    logic               neg_rem_q, neg_rem_d;
    logic [2*WIDTH-1:0] result_q, result_d;

    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     shifted, diff;
    logic [WIDTH-1:0]   step_quo, step_rem;
    logic [WIDTH-1:0]   fin_quo, fin_rem;
    logic               go;

    // Operands are made non-negative here; the sign fix-up is applied to the final result.
    always_comb begin
        abs_a = (bus.signed_div && bus.opdata1[WIDTH-1]) ? -bus.opdata1 : bus.opdata1;
        abs_b = (bus.signed_div && bus.opdata2[WIDTH-1]) ? -bus.opdata2 : bus.opdata2;
    end

    // One restoring step: shift in the next dividend bit and subtract if the divisor fits.
    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        diff    = shifted - {1'b0, dvs_q};
        if (!diff[WIDTH]) begin
            step_rem = diff[WIDTH-1:0];
            step_quo = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            step_rem = shifted[WIDTH-1:0];
            step_quo = {quo_q[WIDTH-2:0], 1'b0};
        end
        fin_quo = neg_quo_q ? -step_quo : step_quo;
        fin_rem = neg_rem_q ? -step_rem : step_rem;
    end

    assign go = bus.start && !bus.annul;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        unique case (state_q)
            FREE: begin
                if (go) begin
                    if (bus.opdata2 == '0) begin
                        state_d = ZERO;
                    end else begin
                        state_d   = ON;
                        cnt_d     = 6'd0;
                        quo_d     = abs_a;
                        rem_d     = '0;
                        dvs_d     = abs_b;
                        neg_quo_d = bus.signed_div && (bus.opdata1[WIDTH-1] ^ bus.opdata2[WIDTH-1]);
                        neg_rem_d = bus.signed_div && bus.opdata1[WIDTH-1];
                    end
                end
            end
            ZERO: begin
                if (!go) begin
                    state_d = FREE;
                end else begin
                    state_d  = DONE;
                    result_d = '0;
                end
            end
            ON: begin
                if (!go) begin
                    state_d = FREE;
                end else begin
                    quo_d = step_quo;
                    rem_d = step_rem;
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        state_d  = DONE;
                        result_d = {fin_rem, fin_quo};
                    end
                end
            end
            DONE: begin
                state_d = FREE;
            end
            default: state_d = FREE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FREE;
            cnt_q     <= 6'd0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
        end
    end

    // The stall drops in DONE so E advances in the same cycle the result is consumed.
    assign bus.stall_div = bus.start && !bus.annul && (state_q != DONE);
    assign bus.ready     = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases, abort/reset and back-to-back divides,
// plus randomized operands compared against an arithmetic reference model.
module tb_div_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    div_unit_if #(.WIDTH(32)) bus ();

    div_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference: DIV truncates toward zero, remainder follows the dividend, x/0 gives 0.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa, sb, q, r;
        logic [31:0] qq, rr;
        if (b == 32'd0) return 64'd0;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q  = sa / sb;
        r  = sa % sb;
        qq = q[31:0];
        rr = r[31:0];
        return {rr, qq};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Entered and left at the start of a cycle (#1 after the edge).
    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input bit keep_start, input string name);
        int          done_idx, stall_cnt, exp_lat;
        logic [63:0] res, exp_res;
        done_idx  = -1;
        stall_cnt = 0;
        res       = 64'd0;
        exp_res   = model(a, b, s);
        exp_lat   = (b == 32'd0) ? 2 : 33;
        bus.opdata1    = a;
        bus.opdata2    = b;
        bus.signed_div = s;
        bus.start      = 1'b1;
        bus.annul      = 1'b0;
        for (int idx = 0; idx < 40; idx++) begin
            #1;
            if (bus.stall_div) stall_cnt++;
            if (bus.ready) begin
                done_idx = idx;
                res      = bus.result;
                if (bus.stall_div) stall_cnt = stall_cnt + 100;
                break;
            end
            next_cycle();
        end
        next_cycle();
        if (!keep_start) bus.start = 1'b0;
        checks++;
        if (done_idx !== exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", name, done_idx, exp_lat);
        end
        checks++;
        if (stall_cnt !== exp_lat) begin
            errors++;
            $display("FAIL %s stall_cycles: got %0d want %0d", name, stall_cnt, exp_lat);
        end
        checks++;
        if (res !== exp_res) begin
            errors++;
            $display("FAIL %s result: got %h want %h (a=%h b=%h s=%0d)", name, res, exp_res, a, b, s);
        end
    endtask

    task automatic test_reset();
        bus.opdata1 = 32'd0; bus.opdata2 = 32'd0; bus.signed_div = 1'b0;
        bus.start = 1'b0; bus.annul = 1'b0;
        rst = 1'b1;
        next_cycle();
        next_cycle();
        checks++;
        if ({bus.ready, bus.stall_div, bus.dbg_state, bus.result} !== {1'b0, 1'b0, 2'd0, 64'd0}) begin
            errors++;
            $display("FAIL reset_outputs: got ready=%b stall=%b st=%0d res=%h want 0 0 0 0",
                     bus.ready, bus.stall_div, bus.dbg_state, bus.result);
        end
        rst = 1'b0;
        next_cycle();
    endtask

    task automatic test_directed();
        do_div(32'd100, 32'd7, 1'b0, 1'b0, "divu_100_7");
        checks++;
        if (model(32'd100, 32'd7, 1'b0) !== {32'd2, 32'd14}) begin
            errors++;
            $display("FAIL model_100_7: got %h want %h", model(32'd100, 32'd7, 1'b0), {32'd2, 32'd14});
        end
        next_cycle();
        do_div(-32'sd7, 32'd2, 1'b1, 1'b0, "div_m7_2");
        next_cycle();
        do_div(32'd7, -32'sd2, 1'b1, 1'b0, "div_7_m2");
        next_cycle();
        do_div(32'h1234_5678, 32'd0, 1'b1, 1'b0, "div_by_zero");
        next_cycle();
    endtask

    task automatic test_annul();
        bus.opdata1 = 32'd1000; bus.opdata2 = 32'd3; bus.signed_div = 1'b0;
        bus.start = 1'b1; bus.annul = 1'b0;
        for (int idx = 0; idx < 10; idx++) next_cycle();
        bus.annul = 1'b1;
        #1;
        checks++;
        if ({bus.stall_div, bus.ready} !== 2'b00) begin
            errors++;
            $display("FAIL annul_cycle: got stall=%b ready=%b want 0 0", bus.stall_div, bus.ready);
        end
        next_cycle();
        bus.annul = 1'b0;
        bus.start = 1'b0;
        #1;
        checks++;
        if ({bus.dbg_state, bus.ready} !== {2'd0, 1'b0}) begin
            errors++;
            $display("FAIL annul_free: got st=%0d ready=%b want 0 0", bus.dbg_state, bus.ready);
        end
        begin
            bit seen_ready;
            seen_ready = 1'b0;
            for (int idx = 0; idx < 40; idx++) begin
                if (bus.ready) seen_ready = 1'b1;
                next_cycle();
            end
            checks++;
            if (seen_ready) begin
                errors++;
                $display("FAIL annul_no_ready: got ready=1 want 0");
            end
        end
    endtask

    task automatic test_annul_at_done();
        bus.opdata1 = 32'd50; bus.opdata2 = 32'd5; bus.signed_div = 1'b0;
        bus.start = 1'b1; bus.annul = 1'b0;
        for (int idx = 0; idx < 33; idx++) next_cycle();
        bus.annul = 1'b1;
        #1;
        checks++;
        if ({bus.ready, bus.stall_div, bus.result} !== {1'b1, 1'b0, 32'd0, 32'd10}) begin
            errors++;
            $display("FAIL annul_at_done: got ready=%b stall=%b res=%h want 1 0 %h",
                     bus.ready, bus.stall_div, bus.result, {32'd0, 32'd10});
        end
        next_cycle();
        bus.annul = 1'b0;
        bus.start = 1'b0;
        next_cycle();
    endtask

    task automatic test_reset_mid_op();
        bus.opdata1 = 32'hDEAD_BEEF; bus.opdata2 = 32'd9; bus.signed_div = 1'b0;
        bus.start = 1'b1; bus.annul = 1'b0;
        for (int idx = 0; idx < 6; idx++) next_cycle();
        rst = 1'b1;
        next_cycle();
        checks++;
        if ({bus.dbg_state, bus.ready, bus.result, bus.stall_div} !== {2'd0, 1'b0, 64'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_mid_op: got st=%0d ready=%b res=%h stall=%b want 0 0 0 1",
                     bus.dbg_state, bus.ready, bus.result, bus.stall_div);
        end
        bus.start = 1'b0;
        rst = 1'b0;
        next_cycle();
        do_div(32'd81, 32'd9, 1'b0, 1'b0, "after_reset");
        next_cycle();
    endtask

    task automatic test_back_to_back();
        do_div(32'hFFFF_FFFF, 32'h10, 1'b0, 1'b1, "b2b_first");
        checks++;
        if ({bus.dbg_state, bus.ready} !== {2'd0, 1'b0}) begin
            errors++;
            $display("FAIL b2b_no_restart: got st=%0d ready=%b want 0 0", bus.dbg_state, bus.ready);
        end
        do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, "b2b_overflow");
        checks++;
        if (model(32'h8000_0000, 32'hFFFF_FFFF, 1'b1) !== {32'd0, 32'h8000_0000}) begin
            errors++;
            $display("FAIL model_overflow: got %h want %h",
                     model(32'h8000_0000, 32'hFFFF_FFFF, 1'b1), {32'd0, 32'h8000_0000});
        end
        next_cycle();
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        logic        s;
        for (int n = 0; n < 24; n++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 15);
                2:       b = $urandom;
                default: b = -($urandom_range(1, 20));
            endcase
            if ($urandom_range(0, 4) == 0) a = 32'h8000_0000;
            s = 1'($urandom_range(0, 1));
            do_div(a, b, s, 1'b1, "random");
            bus.start = 1'b0;
            for (int k = $urandom_range(0, 2); k > 0; k--) next_cycle();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_annul();
        test_annul_at_done();
        test_reset_mid_op();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the operand width; the block only needs to support 32.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port opdata1, input, 32, the dividend (rs), sampled only on the FREE->ON transition.
REQ-005 SHALL have port opdata2, input, 32, the divisor (rt), sampled only on the FREE->ON/ZERO transition.
REQ-006 SHALL have port signed_div, input, 1: 1 means DIV, 0 means DIVU; sampled with the operands.
REQ-007 SHALL have port start, input, 1, a level held high by the E stage while a divide instruction occupies it.
REQ-008 SHALL have port annul, input, 1, the exception flush of E; it aborts the operation.
REQ-009 SHALL have port result, output, 64: {remainder, quotient}, hi = [63:32], lo = [31:0].
REQ-010 SHALL have port ready, output, 1, which is high only while result is valid.
REQ-011 SHALL have port stall_div, output, 1, the stall request to the hazard unit (stall_divE).

Function
REQ-012 SHALL implement the states FREE, ZERO, ON and DONE, held in a registered state variable.
REQ-013 In FREE with start=1, annul=0 and opdata2=0, SHALL go to ZERO.
REQ-014 In FREE with start=1, annul=0 and opdata2!=0, SHALL go to ON, latch the operands and clear the 6-bit counter.
REQ-015 In FREE with start=0 or annul=1, SHALL stay in FREE.
REQ-016 In ZERO, SHALL set result=0 and go to DONE.
REQ-017 In ON, SHALL perform one restoring shift-subtract step per cycle on the absolute-value operands and increment the counter; at counter==31 it SHALL go to DONE with the final quotient and remainder.
REQ-018 In ON or ZERO, if annul=1 or start=0, SHALL go to FREE with no result produced.
REQ-019 In DONE, SHALL hold ready=1 and result valid for exactly one cycle, then go to FREE unconditionally, whatever start is.
REQ-020 SHALL derive stall_div combinationally: stall_div = start & ~annul & (state != DONE).
REQ-021 The stall in REQ-020 SHALL be high from the first cycle start is seen, and low in the DONE cycle so that E advances.
REQ-022 Latency: for start first seen at cycle t with a nonzero divisor, DONE SHALL be at t+33 and stall_div SHALL be high for cycles t..t+32 (33 cycles).
REQ-023 Latency: for a zero divisor, DONE SHALL be at t+2.
REQ-024 Back-to-back divides: if start is still high in the FREE cycle that follows DONE, a new operation SHALL begin in that cycle using the new operands.
REQ-025 Signed rule, quotient: it SHALL be negated when the operand signs differ.
REQ-026 Signed rule, remainder: it SHALL take the sign of the dividend; results are two's complement truncated to 32 bits.
REQ-027 Overflow case: 0x80000000 / 0xFFFFFFFF signed SHALL give quotient 0x80000000 and remainder 0, with no trap.
REQ-028 Unsigned: operands SHALL be treated as 32-bit unsigned values with no sign fix-up.
REQ-029 Outside DONE, ready SHALL be 0 and result SHALL hold its last value; that value is don't-care to consumers.
REQ-030 When annul and the DONE state coincide, ready SHALL still be 1 but stall_div SHALL be 0; the flushed consumer discards the result.

Reset
REQ-031 When rst=1 at a clock edge, the block SHALL set state=FREE, counter=0, result=0, ready=0 and clear the latched operands.
REQ-032 Reset SHALL override every other input in the same cycle, including reset in the middle of an operation.
REQ-033 During reset, stall_div SHALL follow REQ-020 with state=FREE.

Verification
REQ-034 Unsigned: DIVU 100/7, start held -> stall_div high for 33 cycles, then ready=1 with result={32'd2, 32'd14} for one cycle.
REQ-035 Signed: DIV -7/2 -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1); DIV 7/-2 -> quotient 0xFFFFFFFD, remainder 1.
REQ-036 Zero divisor: opdata2=0 -> ready at t+2 with result=0, and stall_div high for exactly 2 cycles.
REQ-037 Abort: annul pulsed at cycle t+10 of an ON operation -> FREE at t+11, ready never asserted and stall_div low at t+10; reset pulsed mid-ON -> all outputs at reset values.
REQ-038 Back-to-back: start held high across two divides, 0xFFFFFFFF/0x10 unsigned then 0x80000000/0xFFFFFFFF signed -> first result {0xF, 0x0FFFFFFF}, second {0, 0x80000000}, and no restart during DONE.
